wb_mux_reg: RTL

Registered, parametrised Wishbone classic 1-to-N interconnect. It decodes the master address against per-slave prefix/mask pairs, giving the lowest-index match priority. It forwards the transfer to the selected slave through a registered request stage and returns a registered, single-cycle termination. It adds what the combinational mux lacks: decode latched per transfer, a per-transfer timeout watchdog, clean abort on master CYC drop, and a transfer status output. It sits between the host-bridge master and the peripheral register slaves.

---
 rtl/wb_mux_reg.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/wb_mux_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_mux_reg : registered Wishbone classic 1-to-N interconnect with watchdog |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wb_mux_reg #(
  parameter int NUM_SLAVES   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255,
  parameter int TO_WIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic                             wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]          wbm_sel_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_cyc_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr_msk,
  output logic                             busy_o,
  output logic [1:0]                       status_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_ACK     = 2'd0;
  localparam logic [1:0] ST_SLV_ERR = 2'd1;
  localparam logic [1:0] ST_DEC_ERR = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t                  state_q;
  logic [NUM_SLAVES-1:0]   sel_oh_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic                    we_q;
  logic [TO_WIDTH-1:0]     cnt_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    rty_q;
  logic [DATA_WIDTH-1:0]   mdat_q;
  logic [1:0]              status_q;

  logic                    hit;
  logic [NUM_SLAVES-1:0]   hit_oh;
  logic                    s_ack;
  logic                    s_err;
  logic                    s_rty;
  logic [DATA_WIDTH-1:0]   s_dat;

  // Address decode: first matching slave wins.
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && (((wbm_adr_i ^ wbs_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &
                    wbs_addr_msk[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0)) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // The strobe one-hot is only non-zero in REQ, so it also gates out
  // terminations from every slave that is not being addressed.
  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_oh_q[i]) begin
        s_ack = wbs_ack_i[i];
        s_err = wbs_err_i[i];
        s_rty = wbs_rty_i[i];
        s_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_oh_q <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      mdat_q   <= '0;
      status_q <= ST_ACK;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
      mdat_q <= '0;
      case (state_q)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            if (hit) begin
              adr_q    <= wbm_adr_i;
              dat_q    <= wbm_dat_i;
              sel_q    <= wbm_sel_i;
              we_q     <= wbm_we_i;
              sel_oh_q <= hit_oh;
              cnt_q    <= '0;
              state_q  <= REQ;
            end else begin
              err_q    <= 1'b1;
              status_q <= ST_DEC_ERR;
              state_q  <= RESP;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + TO_WIDTH'(1);
          if (!wbm_cyc_i) begin
            sel_oh_q <= '0;
            state_q  <= IDLE;
          end else if (s_err || s_rty || s_ack) begin
            sel_oh_q <= '0;
            state_q  <= RESP;
            if (s_err) begin
              err_q    <= 1'b1;
              status_q <= ST_SLV_ERR;
            end else if (s_rty) begin
              rty_q    <= 1'b1;
              status_q <= ST_ACK;
            end else begin
              ack_q    <= 1'b1;
              mdat_q   <= s_dat;
              status_q <= ST_ACK;
            end
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            sel_oh_q <= '0;
            err_q    <= 1'b1;
            status_q <= ST_TIMEOUT;
            state_q  <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    assign wbs_adr_o[g*ADDR_WIDTH +: ADDR_WIDTH]     = adr_q;
    assign wbs_dat_o[g*DATA_WIDTH +: DATA_WIDTH]     = dat_q;
    assign wbs_sel_o[g*SELECT_WIDTH +: SELECT_WIDTH] = sel_q;
    assign wbs_we_o[g]                               = sel_oh_q[g] & we_q;
  end

  assign wbs_stb_o = sel_oh_q;
  assign wbs_cyc_o = sel_oh_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;
  assign wbm_dat_o = mdat_q;
  assign status_o  = status_q;
  assign busy_o    = (state_q != IDLE);

endmodule
`default_nettype wire
